// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared opcodes, FSM encoding and widths for the execute stage
package ex_pkg;

  localparam int EX_DATA_W     = 32;
  localparam int EX_REG_ADDR_W = 4;
  localparam int EX_ALU_OP_W   = 6;

  localparam logic [EX_ALU_OP_W-1:0] OP_ADD  = 6'd0;
  localparam logic [EX_ALU_OP_W-1:0] OP_SUB  = 6'd1;
  localparam logic [EX_ALU_OP_W-1:0] OP_AND  = 6'd2;
  localparam logic [EX_ALU_OP_W-1:0] OP_OR   = 6'd3;
  localparam logic [EX_ALU_OP_W-1:0] OP_XOR  = 6'd4;
  localparam logic [EX_ALU_OP_W-1:0] OP_NOR  = 6'd5;
  localparam logic [EX_ALU_OP_W-1:0] OP_SLT  = 6'd6;
  localparam logic [EX_ALU_OP_W-1:0] OP_SLL  = 6'd7;
  localparam logic [EX_ALU_OP_W-1:0] OP_SRL  = 6'd8;
  localparam logic [EX_ALU_OP_W-1:0] OP_SRA  = 6'd9;
  localparam logic [EX_ALU_OP_W-1:0] OP_MUL  = 6'd10;
  localparam logic [EX_ALU_OP_W-1:0] OP_DIVU = 6'd11;
  localparam logic [EX_ALU_OP_W-1:0] OP_REMU = 6'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIVU = 2'd1,
    MD_REMU = 2'd2
  } md_mode_t;

  function automatic logic is_multi_op(input logic [EX_ALU_OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/ex_stage_unit_muldiv.sv
// rtl/ex_stage_unit_muldiv.sv - iterative shift-add multiplier / restoring divider
module iter_muldiv_unit
  import ex_pkg::*;
#(
  parameter int DATA_W     = EX_DATA_W,
  parameter int ITER_STEPS = EX_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  md_mode_t          mode,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              last_step,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(ITER_STEPS + 1);

  // acc holds the running product (MUL) or partial remainder (DIV/REM);
  // q holds the multiplier or the dividend/quotient shift register.
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   acc;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] m;
  md_mode_t          mode_q;

  logic [DATA_W:0]   r_sh;
  logic [DATA_W:0]   m_ext;
  logic [DATA_W-1:0] prod_sum;

  assign r_sh     = {acc[DATA_W-1:0], q[DATA_W-1]};
  assign m_ext    = {1'b0, m};
  assign prod_sum = acc[DATA_W-1:0] + m;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      q      <= '0;
      m      <= '0;
      mode_q <= MD_MUL;
    end else if (start) begin
      cnt    <= CNT_W'(ITER_STEPS);
      acc    <= '0;
      q      <= op_a;
      m      <= op_b;
      mode_q <= mode;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (mode_q == MD_MUL) begin
        if (q[0]) acc <= {1'b0, prod_sum};
        m <= m << 1;
        q <= q >> 1;
      end else if (r_sh >= m_ext) begin
        // A zero divisor always subtracts, leaving all-ones and the dividend.
        acc <= r_sh - m_ext;
        q   <= {q[DATA_W-2:0], 1'b1};
      end else begin
        acc <= r_sh;
        q   <= {q[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign last_step = (cnt == CNT_W'(1));
  assign result    = (mode_q == MD_DIVU) ? q : acc[DATA_W-1:0];

endmodule

// File: rtl/ex_stage_unit.sv
// rtl/ex_stage_unit.sv - execute stage: ALU, shifter, iterative mul/div, EX/MEM register
module ex_stage_unit
  import ex_pkg::*;
#(
  parameter int DATA_W     = EX_DATA_W,
  parameter int REG_ADDR_W = EX_REG_ADDR_W,
  parameter int ALU_OP_W   = EX_ALU_OP_W,
  parameter int ITER_STEPS = EX_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [ALU_OP_W-1:0]   alu_in,
  input  logic [DATA_W-1:0]     regA_in,
  input  logic [DATA_W-1:0]     regB_in,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [REG_ADDR_W-1:0] regC_adress_in,
  input  logic                  mux4_in,
  input  logic                  data_mem_in,
  input  logic                  write_inst_in,
  input  logic [1:0]            regs_bank_in,
  output logic                  stall_out,
  output logic                  valid_out,
  output logic [DATA_W-1:0]     alu_out,
  output logic [DATA_W-1:0]     regB_out,
  output logic [DATA_W-1:0]     pc_out,
  output logic [REG_ADDR_W-1:0] regC_adress_out,
  output logic                  mux4_out,
  output logic                  data_mem_out,
  output logic                  write_inst_out,
  output logic [1:0]            regs_bank_out,
  output logic                  zero_out,
  output logic                  overflow_out
);

  state_t            state, state_nxt;
  logic              start;
  logic              load_single;
  logic              load_done;
  md_mode_t          md_mode;
  logic              md_last;
  logic [DATA_W-1:0] md_result;
  logic [DATA_W-1:0] sum, diff, alu_res;
  logic              alu_ovf;

  // stall_out depends only on the FSM state and the current ID/EX contents.
  assign start = (state == ST_IDLE) && valid_in && is_multi_op(alu_in);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)   state_nxt = ST_BUSY;
      ST_BUSY: if (md_last) state_nxt = ST_DONE;
      ST_DONE:              state_nxt = ST_IDLE;
      default:              state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_out   = start || (state == ST_BUSY);
    load_single = (state == ST_IDLE) && !start;
    load_done   = (state == ST_DONE);
  end

  always_comb begin
    md_mode = MD_MUL;
    if (alu_in == OP_DIVU) md_mode = MD_DIVU;
    if (alu_in == OP_REMU) md_mode = MD_REMU;
  end

  assign sum  = regA_in + regB_in;
  assign diff = regA_in - regB_in;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_in)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (regA_in[DATA_W-1] == regB_in[DATA_W-1]) && (sum[DATA_W-1] != regA_in[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (regA_in[DATA_W-1] != regB_in[DATA_W-1]) && (diff[DATA_W-1] != regA_in[DATA_W-1]);
      end
      OP_AND: alu_res = regA_in & regB_in;
      OP_OR:  alu_res = regA_in | regB_in;
      OP_XOR: alu_res = regA_in ^ regB_in;
      OP_NOR: alu_res = ~(regA_in | regB_in);
      OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(regA_in) < $signed(regB_in))};
      OP_SLL: alu_res = regA_in << regB_in[4:0];
      OP_SRL: alu_res = regA_in >> regB_in[4:0];
      OP_SRA: alu_res = $unsigned($signed(regA_in) >>> regB_in[4:0]);
      default: alu_res = '0;
    endcase
  end

  iter_muldiv_unit #(
    .DATA_W     (DATA_W),
    .ITER_STEPS (ITER_STEPS)
  ) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (md_mode),
    .op_a      (regA_in),
    .op_b      (regB_in),
    .last_step (md_last),
    .result    (md_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out       <= 1'b0;
      alu_out         <= '0;
      regB_out        <= '0;
      pc_out          <= '0;
      regC_adress_out <= '0;
      mux4_out        <= 1'b0;
      data_mem_out    <= 1'b0;
      write_inst_out  <= 1'b0;
      regs_bank_out   <= '0;
      zero_out        <= 1'b0;
      overflow_out    <= 1'b0;
    end else if (load_done || (load_single && valid_in)) begin
      // The ID/EX sideband is held by the stall, so it is still valid in DONE.
      valid_out       <= 1'b1;
      alu_out         <= load_done ? md_result : alu_res;
      zero_out        <= load_done ? (md_result == '0) : (alu_res == '0);
      overflow_out    <= load_done ? 1'b0 : alu_ovf;
      regB_out        <= regB_in;
      pc_out          <= pc_in;
      regC_adress_out <= regC_adress_in;
      mux4_out        <= mux4_in;
      data_mem_out    <= data_mem_in;
      write_inst_out  <= write_inst_in;
      regs_bank_out   <= regs_bank_in;
    end else begin
      valid_out      <= 1'b0;
      data_mem_out   <= 1'b0;
      write_inst_out <= 1'b0;
    end
  end

endmodule
